conv_pool_layer_gen: RTL and testbench
======================================

Name: conv_pool_layer_gen

Overview:
Parametrised convolution layer engine, successor to the first-layer conv block. It generalises to CI input channels, CO output channels, configurable stride, and per-layer output scaling with saturation. It loads one input feature map (all CI planes) into internal single-port BRAM, then computes conv, ReLU and PxP maxpool per output channel, with one MAC per cycle. Results stream out with a valid/ready handshake to the next layer or FC stage.

Parameters:
I_BW, 8, input pixel width (signed)
W_BW, 8, weight width (signed)
O_BW, 16, output width (signed)
CI, 1, input channels
CO, 4, output channels
I_SIZE, 28, input plane side length (square)
K_SIZE, 5, kernel side length
STRIDE, 1, convolution stride
P_SIZE, 2, maxpool window and stride
O_SHIFT, 4, arithmetic right shift applied before saturation
ADDR_W, 10, BRAM address width; must be at least clog2(CI*I_SIZE*I_SIZE)

Ports:
clk  in  1  clock
global_rst_n  in  1  asynchronous active-low reset
rst_processEnd  in  1  synchronous soft reset to IDLE
ce  in  1  global clock enable; all state frozen when low
i_valid  in  1  input pixel valid
i_ready  out  1  block accepts pixels (high only in IDLE/LOAD)
i_fmap  in  I_BW  pixel, order ci-major then row then column
i_weight  in  CO*CI*K_SIZE*K_SIZE*W_BW  weights; element ((co*CI+ci)*K+ky)*K+kx at [idx*W_BW +: W_BW]
o_valid  out  1  pooled result valid
o_ready  in  1  downstream accepts
o_data  out  O_BW  pooled result
o_ch_end  out  1  with o_valid on the last pooled pixel of a channel
o_allch_end  out  1  one-cycle pulse after the final result of channel CO-1 is accepted

Behaviour:
- Derived sizes: OC = (I_SIZE-K_SIZE)/STRIDE+1 (conv side); OP = OC/P_SIZE (floor; trailing conv rows and columns dropped). ACC width = I_BW+W_BW+clog2(CI*K*K)+1.
- Reset (async or rst_processEnd): state IDLE; all counters 0; o_valid=0, o_data=0, o_ch_end=0, o_allch_end=0, i_ready=1. BRAM contents are not cleared.
- IDLE: the first i_valid&&i_ready moves to LOAD and writes that pixel to address 0.
- LOAD: each accepted pixel is written to the next address. After CI*I_SIZE*I_SIZE pixels, i_ready drops the next cycle and the block goes to COMPUTE. i_valid while i_ready=0 is ignored.
- COMPUTE loop order: co, py, px, then pool position (dy,dx), then ci, ky, kx.
  - Address = ci*I_SIZE^2 + ((py*P+dy)*STRIDE+ky)*I_SIZE + (px*P+dx)*STRIDE+kx.
  - BRAM read latency is 1 cycle. One MAC per cycle into the signed accumulator.
  - At the end of each conv position: relu = max(acc,0). Running max is initialised to 0 at the first position and updated with max(run,relu).
- After P*P positions, go to OUT. o_data = sat(run >>> O_SHIFT) clipped to [0, 2^(O_BW-1)-1]; o_valid=1.
- OUT: o_data, o_valid and o_ch_end are held stable until o_ready. On handshake, advance px/py/co and return to COMPUTE, or go to DONE after the last result.
- Per-result time is CI*K*K*P*P cycles plus a fixed overhead of at most 8 cycles, excluding stall.
- DONE: o_allch_end pulses for one cycle, then IDLE with i_ready=1. The next frame may start immediately.
- ce low: no state, counter, BRAM or output change. Handshakes are not sampled.
- rst_processEnd has priority over everything except the async reset. Mid-LOAD or mid-COMPUTE it aborts the frame; the partial result is not emitted.
- Weights are sampled combinationally and must be stable from LOAD until DONE.

Optional Feature:
BIAS_EN: when defined, adds input port i_bias (CO*O_BW bits, signed, per channel at [co*O_BW +: O_BW]). The bias is added to acc left-shifted by O_SHIFT before ReLU, at each conv position. When undefined, the port is absent and no bias is applied.

Test Plan:
- CI=1,CO=2,I_SIZE=6,K=3,P=2,STRIDE=1,O_SHIFT=0; all pixels 1, all weights 1 -> 8 results, each 9; o_ch_end on results 4 and 8; o_allch_end pulses once.
- Same, channel-1 weights all -1 -> channel 0 outputs 9, channel 1 outputs 0 (ReLU).
- I_SIZE=5,K=5,P=1,CO=1,O_BW=16,O_SHIFT=0; pixels 127, weights 127 -> single result 32767 (saturated; raw 403225).
- CI=2,STRIDE=2,I_SIZE=7,K=3,P=1,CO=1; plane 0 = 1, plane 1 = 2, weights 1, O_SHIFT=1 -> 9 results, each (9+18)>>1 = 13.
- Backpressure: o_ready low for 5 cycles at the first o_valid -> o_data and o_valid unchanged; exactly 8 results total in test 1.
- rst_processEnd mid-COMPUTE -> o_valid=0 next cycle, i_ready=1; a full new frame then reproduces test 1 results; with BIAS_EN, bias 2 on test 1 gives 11.

Source files
------------

// File: rtl/conv_pool_layer_gen.sv
// conv_pool_layer_gen: CI->CO convolution, ReLU, PxP max-pool and saturating scale, one MAC per cycle.
// Defining BIAS_EN adds a per-channel i_bias port added (scaled by 2^O_SHIFT) before ReLU.
module conv_pool_layer_gen #(
  parameter int I_BW    = 8,
  parameter int W_BW    = 8,
  parameter int O_BW    = 16,
  parameter int CI      = 1,
  parameter int CO      = 4,
  parameter int I_SIZE  = 28,
  parameter int K_SIZE  = 5,
  parameter int STRIDE  = 1,
  parameter int P_SIZE  = 2,
  parameter int O_SHIFT = 4,
  parameter int ADDR_W  = 10
) (
  input  logic                                  clk,
  input  logic                                  global_rst_n,
  input  logic                                  rst_processEnd,
  input  logic                                  ce,
  input  logic                                  i_valid,
  output logic                                  i_ready,
  input  logic signed [I_BW-1:0]                i_fmap,
  input  logic [CO*CI*K_SIZE*K_SIZE*W_BW-1:0]   i_weight,
`ifdef BIAS_EN
  input  logic [CO*O_BW-1:0]                    i_bias,
`endif
  output logic                                  o_valid,
  input  logic                                  o_ready,
  output logic [O_BW-1:0]                       o_data,
  output logic                                  o_ch_end,
  output logic                                  o_allch_end
);
  // state     | meaning
  // S_IDLE    | waiting for the first pixel of a frame
  // S_LOAD    | writing the rest of the frame into BRAM
  // S_COMPUTE | issuing taps and accumulating one pooling window
  // S_OUT     | holding a pooled result until o_ready
  // S_DONE    | frame finished, pulse o_allch_end

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int OC    = (I_SIZE - K_SIZE) / STRIDE + 1;
  localparam int OP    = OC / P_SIZE;
  localparam int DEPTH = CI * I_SIZE * I_SIZE;
  localparam int TAPS  = CI * K_SIZE * K_SIZE;
  localparam int ACC_W = I_BW + W_BW + $clog2(TAPS) + 1;
  localparam int RW    = ((ACC_W > O_BW + O_SHIFT) ? ACC_W : O_BW + O_SHIFT) + 1;
  localparam int CO_W  = cw(CO);
  localparam int OP_W  = cw(OP);
  localparam int P_W   = cw(P_SIZE);
  localparam int CI_W  = cw(CI);
  localparam int K_W   = cw(K_SIZE);
  localparam logic [O_BW-1:0] O_MAX = {1'b0, {(O_BW-1){1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_OUT, S_DONE} state_t;

  state_t                   state;
  logic [ADDR_W-1:0]        ld_addr, mem_addr;
  logic [CO_W-1:0]          co;
  logic [OP_W-1:0]          py, px;
  logic [P_W-1:0]           dy, dx;
  logic [CI_W-1:0]          ci;
  logic [K_W-1:0]           ky, kx;
  logic                     iss, mac_v, tap_last_q, pos_last_q;
  logic                     tap_last, pos_last, last_px, last_py, last_co, wr_en;
  logic [31:0]              widx;
  logic signed [W_BW-1:0]   w_sel, w_q;
  logic signed [I_BW-1:0]   rd_q;
  logic signed [I_BW+W_BW-1:0] prod;
  logic signed [ACC_W-1:0]  acc, acc_next;
  logic signed [RW-1:0]     run, bias_term, pre_relu, relu, run_new, shifted;
  logic [O_BW-1:0]          sat_val;
  logic signed [I_BW-1:0]   mem [2**ADDR_W];

  assign tap_last = (ci == CI_W'(CI-1)) && (ky == K_W'(K_SIZE-1)) && (kx == K_W'(K_SIZE-1));
  assign pos_last = tap_last && (dy == P_W'(P_SIZE-1)) && (dx == P_W'(P_SIZE-1));
  assign last_px  = (px == OP_W'(OP-1));
  assign last_py  = (py == OP_W'(OP-1));
  assign last_co  = (co == CO_W'(CO-1));
  assign wr_en    = ce && !rst_processEnd && i_valid && i_ready &&
                    (state == S_IDLE || state == S_LOAD);
  assign widx     = ((32'(co) * CI + 32'(ci)) * K_SIZE + 32'(ky)) * K_SIZE + 32'(kx);
  assign w_sel    = W_BW'(i_weight >> (widx * W_BW));

`ifdef BIAS_EN
  logic signed [O_BW-1:0] bias_sel;
  assign bias_sel  = O_BW'(i_bias >> (32'(co) * O_BW));
  assign bias_term = RW'(bias_sel) <<< O_SHIFT;
`else
  assign bias_term = '0;
`endif

  always_comb begin
    mem_addr = '0;
    if (state == S_LOAD)
      mem_addr = ld_addr;
    else if (state != S_IDLE)
      mem_addr = ADDR_W'(32'(ci) * I_SIZE * I_SIZE
                 + ((32'(py) * P_SIZE + 32'(dy)) * STRIDE + 32'(ky)) * I_SIZE
                 + (32'(px) * P_SIZE + 32'(dx)) * STRIDE + 32'(kx));
    prod     = rd_q * w_q;
    acc_next = acc + ACC_W'(prod);
    pre_relu = RW'(acc_next) + bias_term;
    relu     = pre_relu[RW-1] ? '0 : pre_relu;
    run_new  = (relu > run) ? relu : run;
    shifted  = run_new >>> O_SHIFT;
    sat_val  = (shifted > $signed(RW'(O_MAX))) ? O_MAX : shifted[O_BW-1:0];
  end

  // Single-port frame buffer: one address per cycle, shared by load writes and compute reads.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (wr_en) mem[mem_addr] <= i_fmap;
      rd_q <= mem[mem_addr];
      w_q  <= w_sel;
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state <= S_IDLE; ld_addr <= '0; co <= '0; py <= '0; px <= '0;
      dy <= '0; dx <= '0; ci <= '0; ky <= '0; kx <= '0;
      iss <= 1'b0; mac_v <= 1'b0; tap_last_q <= 1'b0; pos_last_q <= 1'b0;
      acc <= '0; run <= '0; i_ready <= 1'b1;
      o_valid <= 1'b0; o_data <= '0; o_ch_end <= 1'b0; o_allch_end <= 1'b0;
    end else if (ce) begin
      if (rst_processEnd) begin
        state <= S_IDLE; ld_addr <= '0; co <= '0; py <= '0; px <= '0;
        dy <= '0; dx <= '0; ci <= '0; ky <= '0; kx <= '0;
        iss <= 1'b0; mac_v <= 1'b0; tap_last_q <= 1'b0; pos_last_q <= 1'b0;
        acc <= '0; run <= '0; i_ready <= 1'b1;
        o_valid <= 1'b0; o_data <= '0; o_ch_end <= 1'b0; o_allch_end <= 1'b0;
      end else begin
        o_allch_end <= 1'b0;
        case (state)
          S_IDLE: if (i_valid) begin
            ld_addr <= ADDR_W'(1);
            state   <= S_LOAD;
          end
          S_LOAD: if (i_valid) begin
            ld_addr <= ld_addr + 1'b1;
            if (ld_addr == ADDR_W'(DEPTH-1)) begin
              ld_addr <= '0;
              i_ready <= 1'b0;
              iss     <= 1'b1;
              acc     <= '0;
              run     <= '0;
              state   <= S_COMPUTE;
            end
          end
          S_COMPUTE: begin
            mac_v <= iss;
            if (iss) begin
              tap_last_q <= tap_last;
              pos_last_q <= pos_last;
              if (kx != K_W'(K_SIZE-1)) kx <= kx + 1'b1;
              else begin
                kx <= '0;
                if (ky != K_W'(K_SIZE-1)) ky <= ky + 1'b1;
                else begin
                  ky <= '0;
                  if (ci != CI_W'(CI-1)) ci <= ci + 1'b1;
                  else begin
                    ci <= '0;
                    if (dx != P_W'(P_SIZE-1)) dx <= dx + 1'b1;
                    else begin
                      dx <= '0;
                      if (dy != P_W'(P_SIZE-1)) dy <= dy + 1'b1;
                      else begin
                        dy  <= '0;
                        iss <= 1'b0;
                      end
                    end
                  end
                end
              end
            end
            // MAC stage trails the issue stage by the one-cycle BRAM read.
            if (mac_v) begin
              if (tap_last_q) begin
                acc <= '0;
                run <= run_new;
                if (pos_last_q) begin
                  o_valid  <= 1'b1;
                  o_data   <= sat_val;
                  o_ch_end <= last_px && last_py;
                  state    <= S_OUT;
                end
              end else begin
                acc <= acc_next;
              end
            end
          end
          S_OUT: if (o_ready) begin
            o_valid  <= 1'b0;
            o_ch_end <= 1'b0;
            if (!last_px) px <= px + 1'b1;
            else begin
              px <= '0;
              if (!last_py) py <= py + 1'b1;
              else begin
                py <= '0;
                co <= last_co ? '0 : co + 1'b1;
              end
            end
            if (last_px && last_py && last_co) state <= S_DONE;
            else begin
              iss   <= 1'b1;
              run   <= '0;
              state <= S_COMPUTE;
            end
          end
          S_DONE: begin
            o_allch_end <= 1'b1;
            i_ready     <= 1'b1;
            state       <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_pool_layer_gen.sv
// Bench for conv_pool_layer_gen: three parameterisations behind a shared stimulus bus selected by sel.
module tb_conv_pool_layer_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              global_rst_n, rst_processEnd, ce, i_valid, o_ready;
  logic signed [7:0] i_fmap;
  logic [1:0]        sel;
  logic [143:0]      w_a, w_d;
  logic [199:0]      w_c;
  logic              ir_a, ir_c, ir_d, ov_a, ov_c, ov_d, oc_a, oc_c, oc_d, oe_a, oe_c, oe_d;
  logic [15:0]       od_a, od_c, od_d;
  logic              i_ready, o_valid, o_ch_end, o_allch_end;
  logic [15:0]       o_data;
`ifdef BIAS_EN
  logic [31:0]       b_a;
`endif

  conv_pool_layer_gen #(.CI(1), .CO(2), .I_SIZE(6), .K_SIZE(3), .STRIDE(1), .P_SIZE(2),
                        .O_SHIFT(0), .ADDR_W(10)) dut_a (
    .clk(clk), .global_rst_n(global_rst_n), .rst_processEnd(rst_processEnd), .ce(ce),
    .i_valid(i_valid && sel == 2'd0), .i_ready(ir_a), .i_fmap(i_fmap), .i_weight(w_a),
`ifdef BIAS_EN
    .i_bias(b_a),
`endif
    .o_valid(ov_a), .o_ready(o_ready && sel == 2'd0), .o_data(od_a),
    .o_ch_end(oc_a), .o_allch_end(oe_a));

  conv_pool_layer_gen #(.CI(1), .CO(1), .I_SIZE(5), .K_SIZE(5), .STRIDE(1), .P_SIZE(1),
                        .O_SHIFT(0), .ADDR_W(10)) dut_c (
    .clk(clk), .global_rst_n(global_rst_n), .rst_processEnd(rst_processEnd), .ce(ce),
    .i_valid(i_valid && sel == 2'd1), .i_ready(ir_c), .i_fmap(i_fmap), .i_weight(w_c),
`ifdef BIAS_EN
    .i_bias(16'd0),
`endif
    .o_valid(ov_c), .o_ready(o_ready && sel == 2'd1), .o_data(od_c),
    .o_ch_end(oc_c), .o_allch_end(oe_c));

  conv_pool_layer_gen #(.CI(2), .CO(1), .I_SIZE(7), .K_SIZE(3), .STRIDE(2), .P_SIZE(1),
                        .O_SHIFT(1), .ADDR_W(10)) dut_d (
    .clk(clk), .global_rst_n(global_rst_n), .rst_processEnd(rst_processEnd), .ce(ce),
    .i_valid(i_valid && sel == 2'd2), .i_ready(ir_d), .i_fmap(i_fmap), .i_weight(w_d),
`ifdef BIAS_EN
    .i_bias(16'd0),
`endif
    .o_valid(ov_d), .o_ready(o_ready && sel == 2'd2), .o_data(od_d),
    .o_ch_end(oc_d), .o_allch_end(oe_d));

  always_comb begin
    case (sel)
      2'd1:    begin i_ready = ir_c; o_valid = ov_c; o_data = od_c; o_ch_end = oc_c; o_allch_end = oe_c; end
      2'd2:    begin i_ready = ir_d; o_valid = ov_d; o_data = od_d; o_ch_end = oc_d; o_allch_end = oe_d; end
      default: begin i_ready = ir_a; o_valid = ov_a; o_data = od_a; o_ch_end = oc_a; o_allch_end = oe_a; end
    endcase
  end

  // Frame for the CO=2, 6x6 instance: pixel mode, pixel scale, channel weights, expected results.
  // mode 0: pix, 1: pix*col, 2: pix*row. wm: channel-0 weight only on kernel column 2.
  typedef struct packed {
    logic [1:0]        mode;
    logic signed [7:0] pix;
    logic signed [7:0] w0;
    logic signed [7:0] w1;
    logic              wm;
    logic              gaps;
    logic [3:0][15:0]  e0;
    logic [3:0][15:0]  e1;
  } vec_t;

  vec_t vecs [7];
  int   exp_q [$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic vec_t mk(input int mode, input int pix, input int w0, input int w1,
                              input bit wm, input bit gaps,
                              input int a0, input int a1, input int a2, input int a3,
                              input int b0, input int b1, input int b2, input int b3);
    vec_t v;
    v.mode = 2'(mode); v.pix = 8'(pix); v.w0 = 8'(w0); v.w1 = 8'(w1);
    v.wm = wm; v.gaps = gaps;
    v.e0 = {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    v.e1 = {16'(b3), 16'(b2), 16'(b1), 16'(b0)};
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [7:0] pixel(input int mode, input int pix, input int c_i,
                                       input int r, input int c);
    int v;
    case (mode)
      0:       v = pix;
      1:       v = pix * c;
      2:       v = pix * r;
      default: v = pix * (c_i + 1);
    endcase
    return 8'(v);
  endfunction

  task automatic set_wa(input int w0, input int w1, input bit wm);
    for (int i = 0; i < 9; i++) begin
      w_a[i*8 +: 8]     = (wm && (i % 3) != 2) ? 8'd0 : 8'(w0);
      w_a[(9+i)*8 +: 8] = 8'(w1);
    end
  endtask

  // Enters and leaves at a negedge. Garbage pixels (100) are offered while ce is low and after the
  // frame, when they must not be written.
  task automatic load_frame(input int mode, input int pix, input int sz, input int nci, input bit gaps);
    int n = 0;
    for (int c_i = 0; c_i < nci; c_i++)
      for (int r = 0; r < sz; r++)
        for (int c = 0; c < sz; c++) begin
          if (gaps && (n % 3) == 1) begin
            ce = 1'b0; i_valid = 1'b1; i_fmap = 8'sd100;
            @(posedge clk); #1;
            ce = 1'b1;
          end
          i_valid = 1'b1;
          i_fmap  = pixel(mode, pix, c_i, r, c);
          @(posedge clk); #1;
          n++;
        end
    i_fmap = 8'sd100;
    @(negedge clk);
    check("i_ready_drop", i_ready, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  // Enters at a negedge; accepts every result immediately.
  task automatic collect(input int nres, input int per_ch, input string tag);
    int k = 0, cyc = 0, ends = 0, extra = 0;
    o_ready = 1'b1;
    while (k < nres && cyc < 5000) begin
      if (o_allch_end) ends++;
      if (o_valid) begin
        check($sformatf("%s_data%0d", tag, k), o_data, exp_q[k]);
        check($sformatf("%s_ch_end%0d", tag, k), o_ch_end, (k % per_ch) == per_ch - 1);
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s_count", tag), k, nres);
    repeat (6) begin
      if (o_allch_end) ends++;
      if (o_valid) extra++;
      @(negedge clk);
    end
    check($sformatf("%s_allch_end_pulses", tag), ends, 1);
    check($sformatf("%s_extra_results", tag), extra, 0);
  endtask

  task automatic fill_exp(input vec_t v);
    exp_q.delete();
    for (int j = 0; j < 4; j++) exp_q.push_back(int'(v.e0[j]));
    for (int j = 0; j < 4; j++) exp_q.push_back(int'(v.e1[j]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   cyc, cnt;
    logic [15:0] d0;

    vecs[0] = mk(0,  1,  1,  1, 0, 0,  9,  9,  9,  9,   9,  9,  9,  9);
    vecs[1] = mk(0,  1,  1, -1, 0, 0,  9,  9,  9,  9,   0,  0,  0,  0);
    vecs[2] = mk(1,  1,  1, -1, 0, 1, 18, 36, 18, 36,   0,  0,  0,  0);
    vecs[3] = mk(2,  1,  1,  2, 0, 0, 18, 18, 36, 36,  36, 36, 72, 72);
    vecs[4] = mk(1,  1,  1,  1, 1, 0,  9, 15,  9, 15,  18, 36, 18, 36);
    vecs[5] = mk(0, -1, -2,  1, 0, 0, 18, 18, 18, 18,   0,  0,  0,  0);
    vecs[6] = mk(0,  2,  3,  1, 0, 0, 54, 54, 54, 54,  18, 18, 18, 18);

    global_rst_n = 1'b0; rst_processEnd = 1'b0; ce = 1'b1; i_valid = 1'b0;
    o_ready = 1'b0; i_fmap = '0; sel = 2'd0;
    w_a = '0; w_c = {25{8'd127}}; w_d = {18{8'd1}};
`ifdef BIAS_EN
    b_a = '0;
`endif
    repeat (2) @(negedge clk);
    global_rst_n = 1'b1;
    @(negedge clk);
    check("rst_i_ready", i_ready, 1);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_ch_end", o_ch_end, 0);
    check("rst_o_allch_end", o_allch_end, 0);

    for (int i = 0; i < 7; i++) begin
      set_wa(int'(vecs[i].w0), int'(vecs[i].w1), vecs[i].wm);
      fill_exp(vecs[i]);
      check($sformatf("v%0d_i_ready_idle", i), i_ready, 1);
      load_frame(int'(vecs[i].mode), int'(vecs[i].pix), 6, 1, vecs[i].gaps);
      if (i == 0) begin
        // Backpressure on the first result, then ce low with o_ready high.
        o_ready = 1'b0;
        cyc = 0;
        while (!o_valid && cyc < 200) begin @(negedge clk); cyc++; end
        check("bp_first_valid", o_valid, 1);
        d0 = o_data;
        check("bp_first_data", d0, exp_q[0]);
        repeat (5) begin
          @(negedge clk);
          check("bp_valid_hold", o_valid, 1);
          check("bp_data_hold", o_data, d0);
        end
        ce = 1'b0; o_ready = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("ce_low_valid_hold", o_valid, 1);
        end
        o_ready = 1'b0; ce = 1'b1;
      end
      collect(8, 4, $sformatf("v%0d", i));
    end

    // Abort mid-COMPUTE, then a clean frame.
    set_wa(1, 1, 0);
    fill_exp(vecs[0]);
    load_frame(0, 1, 6, 1, 0);
    repeat (10) @(negedge clk);
    rst_processEnd = 1'b1;
    @(posedge clk); #1;
    rst_processEnd = 1'b0;
    @(negedge clk);
    check("abort_o_valid", o_valid, 0);
    check("abort_i_ready", i_ready, 1);
    cnt = 0;
    repeat (60) begin @(negedge clk); if (o_valid) cnt++; end
    check("abort_no_partial", cnt, 0);
    load_frame(0, 1, 6, 1, 0);
    collect(8, 4, "post_abort");

    // Abort mid-LOAD with junk already written, then a clean frame.
    i_valid = 1'b1; i_fmap = 8'sd50;
    repeat (10) @(posedge clk);
    #1 rst_processEnd = 1'b1;
    @(posedge clk); #1;
    rst_processEnd = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    check("load_abort_i_ready", i_ready, 1);
    load_frame(0, 1, 6, 1, 0);
    collect(8, 4, "post_load_abort");

`ifdef BIAS_EN
    b_a = {16'd2, 16'd2};
    exp_q.delete();
    repeat (8) exp_q.push_back(11);
    load_frame(0, 1, 6, 1, 0);
    collect(8, 4, "bias");
    b_a = '0;
`endif

    // Saturation: 25 * 127 * 127 = 403225 clips to 32767.
    sel = 2'd1;
    @(negedge clk);
    check("c_i_ready_idle", i_ready, 1);
    exp_q.delete();
    exp_q.push_back(32767);
    load_frame(0, 127, 5, 1, 0);
    collect(1, 1, "sat");

    // Two channels, stride 2: (9*1 + 9*2) >>> 1 = 13 at each of 3x3 positions.
    sel = 2'd2;
    @(negedge clk);
    check("d_i_ready_idle", i_ready, 1);
    exp_q.delete();
    repeat (9) exp_q.push_back(13);
    load_frame(3, 1, 7, 2, 0);
    collect(9, 9, "stride2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
